// File: rtl/hub75_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hub75_pkg
//  Description : Shared types and constants for the HUB75 receive path.
//                rgb_t        - one colour triple {r,g,b}
//                pixel_pair_t - top-half and bottom-half colour of a column
//                burst_state_t- replay FSM state encoding
//  Revision    : 1.0 - initial release
// ============================================================================
package hub75_pkg;

    localparam int HUB75_LINE_BITS = 64;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_t;

    // Packs as {r1,g1,b1,r2,g2,b2}, matching the order of the HUB75 data pins.
    typedef struct packed {
        rgb_t top;
        rgb_t bot;
    } pixel_pair_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } burst_state_t;

endpackage
`default_nettype wire

// File: rtl/hub75_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : hub75_edge_sync
//  Description : Input register stage for the HUB75 receive path. Every HUB75
//                input is registered once (s1); the shift clock and latch are
//                registered a second time (s2) so that rising edges can be
//                detected as s1 & ~s2. Data, row address and OE leave from s1,
//                aligned with the rise pulses.
//  Ports       : clk, n_rst          - system clock, sync active-low reset
//                i_hub_clk/latch/oe  - raw HUB75 control inputs
//                i_hub_data          - {r1,g1,b1,r2,g2,b2}
//                i_hub_mux           - row address {d,c,b,a}
//                o_clk_rise          - one-cycle pulse per shift-clock rise
//                o_latch_rise        - one-cycle pulse per latch rise
//                o_s1_data/mux/oe    - s1-registered data, address and OE
//  Revision    : 1.0 - initial release
// ============================================================================
module hub75_edge_sync
    import hub75_pkg::*;
#(
    parameter int MUX_LENGTH = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  i_hub_clk,
    input  logic                  i_hub_latch,
    input  logic                  i_hub_oe,
    input  pixel_pair_t           i_hub_data,
    input  logic [MUX_LENGTH-1:0] i_hub_mux,
    output logic                  o_clk_rise,
    output logic                  o_latch_rise,
    output logic                  o_s1_oe,
    output pixel_pair_t           o_s1_data,
    output logic [MUX_LENGTH-1:0] o_s1_mux
);

    logic                  r_s1_clk;
    logic                  r_s1_latch;
    logic                  r_s1_oe;
    pixel_pair_t           r_s1_data;
    logic [MUX_LENGTH-1:0] r_s1_mux;
    logic                  r_s2_clk;
    logic                  r_s2_latch;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_s1_clk   <= 1'b0;
            r_s1_latch <= 1'b0;
            r_s1_oe    <= 1'b0;
            r_s1_data  <= '0;
            r_s1_mux   <= '0;
            r_s2_clk   <= 1'b0;
            r_s2_latch <= 1'b0;
        end else begin
            r_s1_clk   <= i_hub_clk;
            r_s1_latch <= i_hub_latch;
            r_s1_oe    <= i_hub_oe;
            r_s1_data  <= i_hub_data;
            r_s1_mux   <= i_hub_mux;
            r_s2_clk   <= r_s1_clk;
            r_s2_latch <= r_s1_latch;
        end
    end

    assign o_clk_rise   = r_s1_clk & ~r_s2_clk;
    assign o_latch_rise = r_s1_latch & ~r_s2_latch;
    assign o_s1_oe      = r_s1_oe;
    assign o_s1_data    = r_s1_data;
    assign o_s1_mux     = r_s1_mux;

endmodule
`default_nettype wire

// File: rtl/hub75_rx.sv
`default_nettype none
// ============================================================================
//  Module      : hub75_rx
//  Description : HUB75 receiver. Deserialises each latched scan line into a
//                hold buffer and replays it as a ready/valid per-column pixel
//                stream, tagged with row address. Also measures OE-low time
//                per latch interval, counts accepted lines and flags
//                malformed (wrong bit count) and overrun latches.
//  Ports       : clk, n_rst, en, clear_err      - control
//                hub_clk, hub_r1..hub_b2, hub_mux, hub_latch, hub_oe
//                                               - HUB75 input stream
//                px_valid/px_ready/px_col/px_row/px_top/px_bot/px_last
//                                               - pixel replay stream
//                last_on_cycles, line_count, err_len, err_ovr - status
//  Revision    : 1.0 - initial release
// ============================================================================
module hub75_rx
    import hub75_pkg::*;
#(
    parameter int MATRIX_WIDTH  = HUB75_LINE_BITS,
    parameter int COLUMN_LENGTH = 6,
    parameter int BIT_CNT_WIDTH = 7,
    parameter int MUX_LENGTH    = 4,
    parameter int ON_CNT_WIDTH  = 17
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     en,
    input  logic                     clear_err,
    input  logic                     hub_clk,
    input  logic                     hub_r1,
    input  logic                     hub_g1,
    input  logic                     hub_b1,
    input  logic                     hub_r2,
    input  logic                     hub_g2,
    input  logic                     hub_b2,
    input  logic [MUX_LENGTH-1:0]    hub_mux,
    input  logic                     hub_latch,
    input  logic                     hub_oe,
    output logic                     px_valid,
    input  logic                     px_ready,
    output logic [COLUMN_LENGTH-1:0] px_col,
    output logic [MUX_LENGTH-1:0]    px_row,
    output logic [2:0]               px_top,
    output logic [2:0]               px_bot,
    output logic                     px_last,
    output logic [ON_CNT_WIDTH-1:0]  last_on_cycles,
    output logic [15:0]              line_count,
    output logic                     err_len,
    output logic                     err_ovr
);

    localparam logic [BIT_CNT_WIDTH-1:0] c_bit_cnt_max = '1;
    localparam logic [BIT_CNT_WIDTH-1:0] c_line_bits   = BIT_CNT_WIDTH'(MATRIX_WIDTH);
    localparam logic [COLUMN_LENGTH-1:0] c_last_col    = COLUMN_LENGTH'(MATRIX_WIDTH - 1);
    localparam logic [ON_CNT_WIDTH-1:0]  c_on_cnt_max  = '1;

    // ---------------------------------------------------------------- inputs
    pixel_pair_t           w_hub_px;
    pixel_pair_t           w_s1_px;
    logic [MUX_LENGTH-1:0] w_s1_mux;
    logic                  w_s1_oe;
    logic                  w_clk_rise;
    logic                  w_latch_rise;

    assign w_hub_px = {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2};

    hub75_edge_sync #(
        .MUX_LENGTH (MUX_LENGTH)
    ) u_edge_sync (
        .clk          (clk),
        .n_rst        (n_rst),
        .i_hub_clk    (hub_clk),
        .i_hub_latch  (hub_latch),
        .i_hub_oe     (hub_oe),
        .i_hub_data   (w_hub_px),
        .i_hub_mux    (hub_mux),
        .o_clk_rise   (w_clk_rise),
        .o_latch_rise (w_latch_rise),
        .o_s1_oe      (w_s1_oe),
        .o_s1_data    (w_s1_px),
        .o_s1_mux     (w_s1_mux)
    );

    logic w_shift_en;
    logic w_latch_ev;
    logic w_oe_active;

    assign w_shift_en  = en & w_clk_rise;
    assign w_latch_ev  = en & w_latch_rise;
    assign w_oe_active = ~w_s1_oe;

    // ------------------------------------------------------- shift register
    // New bits enter at index 0 and move up, so after a full line the first
    // bit shifted sits at column MATRIX_WIDTH-1 and the last one at column 0.
    // w_shift_next is also what the hold buffer copies, so a shift landing in
    // the same cycle as the latch is part of the captured line.
    pixel_pair_t r_shift      [MATRIX_WIDTH];
    pixel_pair_t r_hold       [MATRIX_WIDTH];
    pixel_pair_t w_shift_next [MATRIX_WIDTH];

    assign w_shift_next[0] = w_shift_en ? w_s1_px : r_shift[0];

    for (genvar gi = 1; gi < MATRIX_WIDTH; gi++) begin : g_shift
        assign w_shift_next[gi] = w_shift_en ? r_shift[gi-1] : r_shift[gi];
    end

    // --------------------------------------------------- latch decisions
    burst_state_t             r_state;
    logic [BIT_CNT_WIDTH-1:0] r_bit_cnt;
    logic [BIT_CNT_WIDTH-1:0] w_bit_cnt_inc;
    logic [BIT_CNT_WIDTH-1:0] w_bit_cnt_line;
    logic                     w_len_ok;
    logic                     w_busy;
    logic                     w_accept;
    logic                     w_new_err_len;
    logic                     w_new_err_ovr;

    assign w_bit_cnt_inc  = (r_bit_cnt == c_bit_cnt_max) ? r_bit_cnt
                                                         : r_bit_cnt + BIT_CNT_WIDTH'(1);
    assign w_bit_cnt_line = w_shift_en ? w_bit_cnt_inc : r_bit_cnt;
    assign w_len_ok       = (w_bit_cnt_line == c_line_bits);
    assign w_busy         = (r_state == ST_BURST);

    assign w_new_err_len  = w_latch_ev & ~w_len_ok;
    assign w_new_err_ovr  = w_latch_ev &  w_len_ok &  w_busy;
    assign w_accept       = w_latch_ev &  w_len_ok & ~w_busy;

    // Shift and hold storage carry no reset: their contents are only ever
    // observed after a full, freshly shifted line has been accepted.
    always_ff @(posedge clk) begin
        r_shift <= w_shift_next;
        if (w_accept) begin
            r_hold <= w_shift_next;
        end
    end

    // ------------------------------------------------------------ burst FSM
    logic                     r_px_valid;
    logic [COLUMN_LENGTH-1:0] r_px_col;
    logic [MUX_LENGTH-1:0]    r_px_row;
    rgb_t                     r_px_top;
    rgb_t                     r_px_bot;
    logic                     r_px_last;
    logic [COLUMN_LENGTH-1:0] w_col_next;

    assign w_col_next = r_px_col + COLUMN_LENGTH'(1);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state    <= ST_IDLE;
            r_px_valid <= 1'b0;
            r_px_col   <= '0;
            r_px_row   <= '0;
            r_px_top   <= '0;
            r_px_bot   <= '0;
            r_px_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state    <= ST_BURST;
                        r_px_valid <= 1'b1;
                        r_px_col   <= '0;
                        r_px_row   <= w_s1_mux;
                        r_px_top   <= w_shift_next[0].top;
                        r_px_bot   <= w_shift_next[0].bot;
                        r_px_last  <= (c_last_col == '0);
                    end
                end
                ST_BURST: begin
                    if (px_ready) begin
                        if (r_px_last) begin
                            r_state    <= ST_IDLE;
                            r_px_valid <= 1'b0;
                            r_px_last  <= 1'b0;
                        end else begin
                            r_px_col  <= w_col_next;
                            r_px_top  <= r_hold[w_col_next].top;
                            r_px_bot  <= r_hold[w_col_next].bot;
                            r_px_last <= (w_col_next == c_last_col);
                        end
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_px_valid <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------- counters, OE meter, error flags
    logic [ON_CNT_WIDTH-1:0] r_on_cnt;
    logic [ON_CNT_WIDTH-1:0] r_last_on;
    logic [15:0]             r_line_count;
    logic                    r_err_len;
    logic                    r_err_ovr;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_bit_cnt    <= '0;
            r_on_cnt     <= '0;
            r_last_on    <= '0;
            r_line_count <= '0;
            r_err_len    <= 1'b0;
            r_err_ovr    <= 1'b0;
        end else begin
            if (!en || w_latch_ev) begin
                r_bit_cnt <= '0;
            end else begin
                r_bit_cnt <= w_bit_cnt_line;
            end

            // An OE-low latch cycle already belongs to the next interval.
            if (w_latch_ev) begin
                r_last_on <= r_on_cnt;
                r_on_cnt  <= w_oe_active ? ON_CNT_WIDTH'(1) : '0;
            end else if (w_oe_active && (r_on_cnt != c_on_cnt_max)) begin
                r_on_cnt  <= r_on_cnt + ON_CNT_WIDTH'(1);
            end

            if (w_accept) begin
                r_line_count <= r_line_count + 16'd1;
            end

            // A new error in the clearing cycle keeps the flag set.
            r_err_len <= (r_err_len & ~clear_err) | w_new_err_len;
            r_err_ovr <= (r_err_ovr & ~clear_err) | w_new_err_ovr;
        end
    end

    assign px_valid       = r_px_valid;
    assign px_col         = r_px_col;
    assign px_row         = r_px_row;
    assign px_top         = r_px_top;
    assign px_bot         = r_px_bot;
    assign px_last        = r_px_last;
    assign last_on_cycles = r_last_on;
    assign line_count     = r_line_count;
    assign err_len        = r_err_len;
    assign err_ovr        = r_err_ovr;

endmodule
`default_nettype wire

// File: doc/hub75_rx.md
Name: hub75_rx

Overview:
- Receive end of the HUB75 panel interface: samples the clk_out/r1..b2/a..d/latch_SR/oe stream that the LED driver path emits, and deserializes each latched scan line.
- Each accepted line is replayed as a handshaked per-column pixel stream, together with row address and measured OE on-time.
- Used as a loopback monitor in the LED-matrix block and as the front end of a future panel-chaining/capture feature.

Parameters:
- MATRIX_WIDTH, 64, columns per scan line (bits per latch).
- COLUMN_LENGTH, 6, log2(MATRIX_WIDTH); width of px_col.
- BIT_CNT_WIDTH, 7, width of the saturating shift-edge counter (≥ COLUMN_LENGTH+1).
- MUX_LENGTH, 4, width of the row address a..d.
- ON_CNT_WIDTH, 17, width of the OE-active cycle counter.

Ports:
- clk  in  1  system clock; HUB75 inputs are synchronous to this domain.
- n_rst  in  1  synchronous, active-low reset.
- en  in  1  capture enable.
- clear_err  in  1  one-cycle pulse; clears sticky error flags.
- hub_clk  in  1  HUB75 shift clock; rising edge shifts.
- hub_r1, hub_g1, hub_b1  in  1 each  top-half colour bits.
- hub_r2, hub_g2, hub_b2  in  1 each  bottom-half colour bits.
- hub_mux  in  MUX_LENGTH  row address {d,c,b,a}.
- hub_latch  in  1  active-high latch.
- hub_oe  in  1  active-low output enable.
- px_valid  out  1  pixel beat valid.
- px_ready  in  1  consumer ready.
- px_col  out  COLUMN_LENGTH  column of current beat.
- px_row  out  MUX_LENGTH  row address of the line.
- px_top  out  3  {r1,g1,b1} for px_col.
- px_bot  out  3  {r2,g2,b2} for px_col.
- px_last  out  1  high on beat px_col == MATRIX_WIDTH-1.
- last_on_cycles  out  ON_CNT_WIDTH  OE-low cycles measured in the previous latch interval.
- line_count  out  16  accepted lines, wraps.
- err_len  out  1  sticky: latch seen with bit count ≠ MATRIX_WIDTH.
- err_ovr  out  1  sticky: valid line latched while a burst was still active.

Behaviour:
- Input stage: all hub_* inputs are registered once (s1), and hub_clk/hub_latch are registered again (s2).
  - Rise = s1 & ~s2.
  - Data and mux are taken from s1 in the rise cycle.
- Shift: on a hub_clk rise with en=1, shift the 6 colour bits into a MATRIX_WIDTH×6 shift register.
  - bit_cnt increments and saturates at 2^BIT_CNT_WIDTH-1.
  - The first bit after a latch ends at column MATRIX_WIDTH-1; the last bit is column 0.
  - More than MATRIX_WIDTH edges: the register keeps the last MATRIX_WIDTH bits.
- Latch rise with en=1:
  - bit_cnt ≠ MATRIX_WIDTH → set err_len; line dropped.
  - else, burst active → set err_ovr; line dropped.
  - else → copy the shift register into the hold buffer, capture px_row from s1 hub_mux, increment line_count, start the burst.
  - In all three cases bit_cnt clears to 0.
- Simultaneous hub_clk rise and latch rise in the same cycle: the shift is applied first, and the bit counts toward the line being latched.
- Burst FSM states: IDLE, BURST.
  - IDLE→BURST on accept; px_valid rises the cycle after the latch-rise cycle, i.e. 2 clk after hub_latch goes high at the port.
  - In BURST: px_valid=1, starting at px_col=0.
  - On px_valid&px_ready: px_col+1. If px_last, return to IDLE with px_valid=0 the next cycle.
  - px_col/px_row/px_top/px_bot/px_last stay stable while px_valid&~px_ready.
- OE meter:
  - on_cnt increments (saturating) every cycle s1 hub_oe=0.
  - On each latch rise, last_on_cycles ← on_cnt, then on_cnt ← 0. If OE is low in that same cycle, on_cnt ← 1.
- en=0:
  - hub_clk and latch rises are ignored; bit_cnt held at 0.
  - An active burst completes normally; the OE meter keeps running.
- clear_err clears err_len/err_ovr next cycle; a same-cycle new error wins (flag stays set).
- Reset (n_rst=0 at a clk edge, any state, including mid-burst): FSM=IDLE, and the following outputs are 0:
  - px_valid, px_col, px_row, px_top, px_bot, px_last
  - last_on_cycles, line_count, err_len, err_ovr
  - bit_cnt, on_cnt, s1/s2 registers.
  - The hold buffer contents are don't-care.

Decomposition:
- hub75_pkg:
  - typedef rgb_t (3 bits r,g,b), typedef pixel_pair_t {rgb_t top, bot}
  - burst state enum
  - localparam HUB75_LINE_BITS = MATRIX_WIDTH.
- Sub-module hub75_edge_sync: input register stage plus rise detection for hub_clk/hub_latch; exposes s1 data.
- Shift/hold buffers, FSM and OE meter live in hub75_rx.

Test Plan:
- Shift 64 columns with column c = {r1=c[0],g1=c[1],b1=c[2],r2=c[3],g2=c[4],b2=c[5]} (first bit = col 63), mux=4'hA, latch, px_ready=1 → 64 beats, col 0..63 with matching data, px_row=A, px_last only at col 63, line_count=1.
- 63 clock edges, then latch → err_len=1, no px_valid, line_count unchanged; clear_err pulse → err_len=0.
- First line accepted with px_ready=0, second 64-bit line latched → err_ovr=1; first burst still delivers 64 correct beats once ready rises.
- OE low for 200 cycles between two latches → last_on_cycles=200 after the second latch.
- px_ready toggled every other cycle → no dropped or duplicated beats; outputs stable while stalled.
- n_rst asserted at beat 30 → next cycle px_valid=0 and all outputs 0; next valid line is received correctly.
